mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath width.
REQ-002 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-003 SHALL have clk  input  1  clock; all state updates on the posedge.
REQ-004 SHALL have rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have in_valid  input  1  MEM-stage instruction present.
REQ-006 SHALL have stall  input  1  hold the current WB contents.
REQ-007 SHALL have flush  input  1  kill the WB contents.
REQ-008 SHALL have reg_write, mem_to_reg  input  1 each  control from MEM.
REQ-009 SHALL have dst  input  REG_AW  destination register.
REQ-010 SHALL have alu_result, mem_rdata  input  DATA_W each  result sources.
REQ-011 SHALL have ld_size  input  2  load size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-012 SHALL have ld_unsigned  input  1  zero-extend when 1.
REQ-013 SHALL have byte_off  input  2  address bits [1:0] of the load.
REQ-014 SHALL have rf_we, rf_waddr, rf_wdata  output  1/REG_AW/DATA_W  register-file write port.
REQ-015 SHALL have fwd_valid, fwd_addr, fwd_data  output  1/REG_AW/DATA_W  bypass to EX.
REQ-016 SHALL have misalign_err  output  1  sticky misaligned-load flag.

Function
REQ-017 Each posedge: flush clears the valid bit; else stall holds all state; else capture in_valid and all inputs. Priority is flush > stall > capture.
REQ-018 Outputs SHALL be combinational from the WB register: one cycle of latency from capture to rf_we. The register file commits on the following negedge.
REQ-019 rf_we SHALL be asserted when all hold: valid & reg_write & (dst != 0) & no misalignment.
REQ-020 A write to register 0 SHALL never assert rf_we.
REQ-021 rf_wdata SHALL be the aligned load data when mem_to_reg = 1, else alu_result.
REQ-022 Byte load: select lane byte_off, then extend bit 7 (signed) or zero-extend.
REQ-023 Half load: select the half given by byte_off[1], then extend bit 15 (signed) or zero-extend.
REQ-024 Word load: pass mem_rdata unchanged.
REQ-025 Misalignment SHALL be: half with byte_off[0] = 1, word with byte_off != 0, or ld_size = 11.
REQ-026 On a valid, captured, misaligned load, rf_we SHALL be suppressed and misalign_err SHALL set and hold until reset.
REQ-027 The fwd_* outputs SHALL equal rf_we/rf_waddr/rf_wdata in the same cycle.
REQ-028 While stalled, rf_we SHALL stay asserted. Repeat writes of identical data are permitted.
REQ-029 With flush and stall together, the stage SHALL be invalidated.

Reset
REQ-030 Asserting rst SHALL immediately clear valid, misalign_err, and all captured fields to 0.
REQ-031 During reset, rf_we, fwd_valid and misalign_err SHALL be 0 and rf_wdata SHALL be 0.
REQ-032 If reset is asserted mid-stall, the held instruction SHALL be lost and no write SHALL occur.

Configuration
REQ-033 Macro WB_RETIRE_CNT_EN, when defined, SHALL add output retire_cnt (32 bits).
REQ-034 retire_cnt SHALL increment once per instruction leaving WB valid and unflushed, that is on a posedge with valid & !stall & !flush. It SHALL be cleared by reset and wrap at 2^32 - 1 -> 0.
REQ-035 Without WB_RETIRE_CNT_EN, the port and counter SHALL be absent, with identical remaining behaviour.

Structure
REQ-036 The shared package SHALL hold the ld_size encodings (LD_BYTE, LD_HALF, LD_WORD) and the default widths.
REQ-037 Load alignment/extension SHALL be a combinational sub-module, load_align (inputs mem_rdata, ld_size, ld_unsigned, byte_off; outputs data, misalign).

Verification
REQ-038 ALU writeback: dst = 8, reg_write = 1, mem_to_reg = 0, alu_result = 0x0000_1234 -> next cycle rf_we = 1, rf_waddr = 8, rf_wdata = 0x0000_1234, fwd equal.
REQ-039 Signed byte load: mem_rdata = 0x80FF_7F01, byte_off = 3, ld_size = 00, ld_unsigned = 0 -> rf_wdata = 0xFFFF_FF80. With ld_unsigned = 1 -> 0x0000_0080.
REQ-040 Half load: byte_off = 2, ld_size = 01, signed, same data -> 0xFFFF_80FF. Then byte_off = 1 -> rf_we = 0 and misalign_err = 1, still 1 after 10 further clean cycles.
REQ-041 dst = 0 with reg_write = 1 -> rf_we = 0, while fwd_valid = 0.
REQ-042 Stall 3 cycles then flush with stall high -> rf_we held 3 cycles, then 0. With WB_RETIRE_CNT_EN, retire_cnt unchanged.
REQ-043 Assert rst asynchronously mid-cycle while valid -> rf_we drops before the next edge, and misalign_err and retire_cnt read 0.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB pipeline stage: load-size encodings
// and default datapath / register-address widths.
package mem_wb_stage_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_AW = 5;

  typedef enum logic [1:0] {
    LD_BYTE = 2'b00,
    LD_HALF = 2'b01,
    LD_WORD = 2'b10,
    LD_RSVD = 2'b11
  } ld_size_e;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the addressed byte/half out of the
// memory word, sign- or zero-extends it, and flags misaligned accesses.
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  input  logic [1:0]        byte_off,
  output logic [DATA_W-1:0] data,
  output logic              misalign
);

  ld_size_e    w_size;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_size = ld_size_e'(ld_size);

  // Lane selection for byte and half accesses
  always_comb begin
    w_byte = mem_rdata[{byte_off, 3'b000} +: 8];
    w_half = mem_rdata[{byte_off[1], 4'b0000} +: 16];
  end

  // Extension and alignment check per load size
  always_comb begin
    data     = mem_rdata;
    misalign = 1'b0;
    unique case (w_size)
      LD_BYTE: data = {{(DATA_W-8){~ld_unsigned & w_byte[7]}}, w_byte};
      LD_HALF: begin
        data     = {{(DATA_W-16){~ld_unsigned & w_half[15]}}, w_half};
        misalign = byte_off[0];
      end
      LD_WORD: misalign = (byte_off != 2'b00);
      LD_RSVD: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with register-file write port, EX bypass and
// sticky misaligned-load flag. Optional feature macro WB_RETIRE_CNT_EN adds
// a 32-bit retired-instruction counter output (retire_cnt).
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [REG_AW-1:0] dst,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  input  logic [1:0]        byte_off,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0]       retire_cnt,
`endif
  output logic              misalign_err
);

  logic              r_valid;
  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic [REG_AW-1:0] r_dst;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_ld_size;
  logic              r_ld_unsigned;
  logic [1:0]        r_byte_off;
  logic              r_err;

  logic [DATA_W-1:0] w_load;
  logic              w_misalign;
  logic              w_mis_load;

  // WB register: flush kills, stall holds, otherwise capture from MEM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid       <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_dst         <= '0;
      r_alu         <= '0;
      r_rdata       <= '0;
      r_ld_size     <= '0;
      r_ld_unsigned <= 1'b0;
      r_byte_off    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_valid       <= in_valid;
      r_reg_write   <= reg_write;
      r_mem_to_reg  <= mem_to_reg;
      r_dst         <= dst;
      r_alu         <= alu_result;
      r_rdata       <= mem_rdata;
      r_ld_size     <= ld_size;
      r_ld_unsigned <= ld_unsigned;
      r_byte_off    <= byte_off;
    end
  end

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .mem_rdata  (r_rdata),
    .ld_size    (r_ld_size),
    .ld_unsigned(r_ld_unsigned),
    .byte_off   (r_byte_off),
    .data       (w_load),
    .misalign   (w_misalign)
  );

  // Alignment only matters for loads; ALU results ignore the load fields
  assign w_mis_load = r_valid & r_mem_to_reg & w_misalign;

  // Sticky error: latched once a misaligned load has been seen in WB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_err <= 1'b0;
    else if (w_mis_load)
      r_err <= 1'b1;
  end

  // Write port and bypass are the same view of the WB register
  always_comb begin
    rf_we        = r_valid & r_reg_write & (r_dst != '0) & ~w_mis_load;
    rf_waddr     = r_dst;
    rf_wdata     = r_mem_to_reg ? w_load : r_alu;
    fwd_valid    = rf_we;
    fwd_addr     = rf_waddr;
    fwd_data     = rf_wdata;
    misalign_err = r_err | w_mis_load;
  end

`ifdef WB_RETIRE_CNT_EN
  // Count instructions leaving WB valid and not killed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      retire_cnt <= '0;
    else if (r_valid & ~stall & ~flush)
      retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed scenarios then random traffic,
// with an instruction-level reference model feeding an expectation queue.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, flush, reg_write, mem_to_reg;
  logic [4:0]  dst;
  logic [31:0] alu_result, mem_rdata;
  logic [1:0]  ld_size, byte_off;
  logic        ld_unsigned;
  logic        rf_we, fwd_valid, misalign_err;
  logic [4:0]  rf_waddr, fwd_addr;
  logic [31:0] rf_wdata, fwd_data;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .dst(dst),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .ld_size(ld_size),
    .ld_unsigned(ld_unsigned), .byte_off(byte_off),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
`ifdef WB_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    bit          rw;
    bit          m2r;
    int unsigned dst;
    bit [31:0]   alu;
    bit [31:0]   rd;
    int unsigned sz;
    bit          uns;
    int unsigned off;
  } instr_t;

  typedef struct {
    bit          in_rst;
    bit          we;
    int unsigned addr;
    bit [31:0]   data;
    bit          err;
    int unsigned cnt;
  } exp_t;

  instr_t      wb;
  bit          m_err;
  int unsigned m_cnt;
  exp_t        q[$];
  int          total = 0;
  int          bad = 0;

  function automatic bit [31:0] ref_load(bit [31:0] rd, int unsigned sz, bit uns, int unsigned off);
    bit [31:0] v;
    if (sz == 0) begin
      v = (rd >> (8 * off)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (rd >> (16 * (off / 2))) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic bit ref_mis(int unsigned sz, int unsigned off);
    return (sz == 3) || (sz == 1 && (off % 2) == 1) || (sz == 2 && off != 0);
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    bit   mis;
    mis      = wb.valid && wb.m2r && ref_mis(wb.sz, wb.off);
    e.in_rst = (rst == 1'b0);
    e.we     = wb.valid && wb.rw && (wb.dst != 0) && !mis;
    e.addr   = wb.dst;
    e.data   = wb.m2r ? ref_load(wb.rd, wb.sz, wb.uns, wb.off) : wb.alu;
    e.err    = m_err || mis;
    e.cnt    = m_cnt;
    return e;
  endfunction

  task automatic model_reset();
    wb    = '{default: 0};
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at it
  task automatic model_step();
    if (!rst) begin
      model_reset();
    end else begin
      if (wb.valid && wb.m2r && ref_mis(wb.sz, wb.off)) m_err = 1'b1;
      if (wb.valid && !stall && !flush) m_cnt++;
      if (flush) wb.valid = 1'b0;
      else if (!stall)
        wb = '{valid: in_valid, rw: reg_write, m2r: mem_to_reg, dst: dst,
               alu: alu_result, rd: mem_rdata, sz: ld_size, uns: ld_unsigned,
               off: byte_off};
    end
    q.push_back(expect_now());
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit rw, input bit m2r, input int unsigned d,
                       input bit [31:0] alu, input bit [31:0] rd, input int unsigned sz,
                       input bit un, input int unsigned off, input bit st, input bit fl);
    in_valid    = v;
    reg_write   = rw;
    mem_to_reg  = m2r;
    dst         = d[4:0];
    alu_result  = alu;
    mem_rdata   = rd;
    ld_size     = sz[1:0];
    ld_unsigned = un;
    byte_off    = off[1:0];
    stall       = st;
    flush       = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Reset asserted between edges: outputs must clear without a clock
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    chk("async_rf_we", {31'd0, rf_we}, 32'd0);
    chk("async_err", {31'd0, misalign_err}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("async_cnt", retire_cnt, 32'd0);
`endif
    void'(q.pop_back());
    model_reset();
    q.push_back(expect_now());
    tick();
    rst = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the queued expectation mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
      chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, e.we});
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.err});
`ifdef WB_RETIRE_CNT_EN
      chk("retire_cnt", retire_cnt, e.cnt);
`endif
      if (e.we || e.in_rst) begin
        chk("rf_waddr", {27'd0, rf_waddr}, e.addr);
        chk("rf_wdata", rf_wdata, e.data);
        chk("fwd_addr", {27'd0, fwd_addr}, e.addr);
        chk("fwd_data", fwd_data, e.data);
      end
    end
  end

  initial begin
    model_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b1;

    // ALU writeback
    drive(1, 1, 0, 8, 32'h0000_1234, 0, 2, 0, 0, 0, 0); tick();
    // Byte loads, signed then unsigned
    drive(1, 1, 1, 5, 0, 32'h80FF_7F01, 0, 0, 3, 0, 0); tick();
    drive(1, 1, 1, 5, 0, 32'h80FF_7F01, 0, 1, 3, 0, 0); tick();
    // Half load aligned, then misaligned
    drive(1, 1, 1, 6, 0, 32'h80FF_7F01, 1, 0, 2, 0, 0); tick();
    drive(1, 1, 1, 6, 0, 32'h80FF_7F01, 1, 0, 1, 0, 0); tick();
    drive(1, 1, 0, 7, 32'h0000_00A5, 0, 2, 0, 0, 0, 0);
    repeat (10) tick();
    // Write to register 0
    drive(1, 1, 0, 0, 32'hDEAD_BEEF, 0, 2, 0, 0, 0, 0); tick();
    // Stall three cycles then flush together with stall
    drive(1, 1, 0, 9, 32'h0000_0099, 0, 2, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 10, 32'h0000_0055, 0, 2, 0, 0, 1, 0);
    repeat (3) tick();
    drive(1, 1, 0, 10, 32'h0000_0055, 0, 2, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0); tick();
    // Reset mid-stall loses the held instruction
    drive(1, 1, 0, 11, 32'h0000_0777, 0, 2, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 12, 32'h0000_0888, 0, 2, 0, 0, 1, 0); tick();
    async_reset();
    drive(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0); tick();

    // Random traffic with occasional stall, flush and reset
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 31), $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 3),
            $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      tick();
      if ($urandom_range(0, 59) == 0) async_reset();
    end

    drive(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
